muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-003 SHALL expose: flush  input  1  pipeline flush; aborts any operation in progress.
REQ-004 SHALL expose: in_valid  input  1  request present from execute stage.
REQ-005 SHALL expose: in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL expose: alufunc  input  alufunc_t  one of MULT, DIV, DIVU, REM, REMU.
REQ-007 SHALL expose: word  input  1  1 = 32-bit W variant (MULW/DIVW/...), 0 = 64-bit.
REQ-008 SHALL expose: a, b  input  64 each  operand 1 (dividend/multiplicand) and operand 2.
REQ-009 SHALL expose: out_valid  output  1  result is valid.
REQ-010 SHALL expose: out_ready  input  1  consumer takes the result.
REQ-011 SHALL expose: result  output  64  final 64-bit value, already sign-extended for W ops.
REQ-012 SHALL expose: busy  output  1  high in any state other than IDLE; drives the pipeline stall.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL assert in_ready only in IDLE with flush=0; a handshake is in_valid & in_ready.
REQ-015 On a handshake SHALL latch alufunc, word, and the operands, then go to MUL (MULT) or DIV (others).
REQ-016 If word=1, SHALL take a[31:0] and b[31:0], sign-extended for MULT/DIV/REM and zero-extended for DIVU/REMU.
REQ-017 MUL SHALL be radix-2 shift-add producing the low 64 bits of the product.
REQ-018 DIV SHALL be radix-2 restoring division on magnitudes, followed by sign fixup.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
REQ-019 SHALL run N iterations, N=64 (word=0) or N=32 (word=1), counted by a 7-bit counter cleared on accept.
REQ-020 For a handshake in cycle T, SHALL present out_valid=1 from cycle T+N+1 (state DONE).
REQ-021 Divide-by-zero (effective b==0) SHALL skip iteration and enter DONE with out_valid=1 at T+1.
  - DIV/DIVU result = all ones.
  - REM/REMU result = effective a.
REQ-022 Signed overflow (DIV/REM, a = most-negative value of the operand width, b = -1) SHALL give out_valid=1 at T+1.
  - DIV result = a.
  - REM result = 0.
REQ-023 For word=1, SHALL set result = sign-extension of the 32-bit result[31:0], for all five functions.
REQ-024 In DONE, SHALL hold result and out_valid stable until out_ready=1, then go to IDLE the next cycle; in_ready stays 0 in DONE.
REQ-025 Any other alufunc value SHALL be accepted and completed at T+1 with result=0.
REQ-026 flush=1 SHALL force IDLE next cycle from any state; out_valid=0 that next cycle; the flushed result is never delivered.
REQ-027 flush and in_valid in the same cycle SHALL not accept the request (flush wins).
REQ-028 In IDLE, MUL and DIV, SHALL hold out_valid=0; result is don't-care while out_valid=0.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE, counter=0, out_valid=0, busy=0, result=0, with priority over flush and handshake.
REQ-030 A reset asserted mid-operation SHALL discard the operation; in_ready=1 on the first cycle after reset deasserts.

Structure
REQ-031 The shared pipes package SHALL hold: the muldiv_state_t enum, MULDIV_XLEN=64, MULDIV_ITER_D=64, MULDIV_ITER_W=32; alufunc_t stays in common.
REQ-032 The block SHALL instantiate one sub-module, muldiv_iter.
  - muldiv_iter is the combinational single-iteration step: shift-add or restore-subtract.
  - FSM, counter, sign fixup and special cases stay in muldiv_ctrl.

Verification
REQ-033 MULT, a=7, b=-3, word=0 -> result=0xFFFF_FFFF_FFFF_FFEB, out_valid first at T+65.
REQ-034 DIV a=-20, b=3 -> 0xFFFF_FFFF_FFFF_FFFA; REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFE; both at T+65.
REQ-035 DIVU a=0x1234, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REMU with the same operands -> 0x1234 at T+1.
REQ-036 DIV word=1, a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at T+1; MULT word=1, a=0x10000, b=0x10000 -> 0 at T+33.
REQ-037 Back-pressure: out_ready held 0 for 5 cycles in DONE -> result stable, busy=1, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 Abort cases:
  - flush at iteration 10 of DIVU -> out_valid never asserts; in_ready=1 next cycle; a new request completes correctly.
  - Same test repeated with reset=0 in place of flush -> same required behaviour.

Source files
------------

// File: rtl/common_pkg.sv
// Shared execute-stage types used across the pipeline blocks.
// No logic, types only.
// No flow control.
package common_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MULT = 4'd8,
    ALU_DIV  = 4'd9,
    ALU_DIVU = 4'd10,
    ALU_REM  = 4'd11,
    ALU_REMU = 4'd12
  } alufunc_t;

endpackage

// File: rtl/muldiv_ctrl_pkg.sv
// Multiply/divide unit types, iteration counts and helpers.
// No logic, types only.
// No flow control.
package muldiv_ctrl_pkg;

  localparam int MULDIV_XLEN   = 64;
  localparam int MULDIV_ITER_D = 64;
  localparam int MULDIV_ITER_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Sign-extend a 32-bit value to the full register width.
  function automatic logic [MULDIV_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MULDIV_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring-subtract divide.
// Purely combinational, zero latency.
// No flow control; the controller decides when to register the outputs.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic                   is_div,
  input  logic [MULDIV_XLEN-1:0] acc,
  input  logic [MULDIV_XLEN-1:0] op_a,
  input  logic [MULDIV_XLEN-1:0] op_b,
  output logic [MULDIV_XLEN-1:0] acc_nxt,
  output logic [MULDIV_XLEN-1:0] op_a_nxt,
  output logic [MULDIV_XLEN-1:0] op_b_nxt
);

  logic [MULDIV_XLEN:0] part;
  logic                 ge;

  // mul: acc=product, op_a=multiplicand, op_b=multiplier
  // div: acc=partial remainder, op_a=dividend/quotient shifter, op_b=divisor
  always_comb begin
    part     = {acc, op_a[MULDIV_XLEN-1]};
    ge       = 1'b0;
    acc_nxt  = acc;
    op_a_nxt = op_a;
    op_b_nxt = op_b;
    if (is_div) begin
      // part can reach 65 bits, but when it is >= divisor the difference fits in 64
      ge       = (part >= {1'b0, op_b});
      acc_nxt  = ge ? (part[MULDIV_XLEN-1:0] - op_b) : part[MULDIV_XLEN-1:0];
      op_a_nxt = {op_a[MULDIV_XLEN-2:0], ge};
    end else begin
      acc_nxt  = op_b[0] ? (acc + op_a) : acc;
      op_a_nxt = {op_a[MULDIV_XLEN-2:0], 1'b0};
      op_b_nxt = {1'b0, op_b[MULDIV_XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: FSM, operand prep, sign fixup, special cases.
// Latency N+1 cycles (N=64 or 32 for W ops); div-by-zero/overflow/unknown ops in 1.
// Valid/ready on both sides; result held in DONE until out_ready, accepts only in IDLE.
module muldiv_ctrl
  import common_pkg::*;
  import muldiv_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  alufunc_t               alufunc,
  input  logic                   word,
  input  logic [MULDIV_XLEN-1:0] a,
  input  logic [MULDIV_XLEN-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MULDIV_XLEN-1:0] result,
  output logic                   busy
);

  muldiv_state_t          state, state_nxt;
  alufunc_t               func_q;
  logic                   word_q, neg_q_q, neg_r_q;
  logic [6:0]             cnt;
  logic [MULDIV_XLEN-1:0] acc_q, opa_q, opb_q, result_q;
  logic [MULDIV_XLEN-1:0] acc_nxt, opa_nxt, opb_nxt;

  logic                   accept, last, rem_q;
  logic                   is_mul, is_sdiv, is_div_op, is_rem;
  logic                   neg_a, neg_b, div0, ovf, special;
  logic [MULDIV_XLEN-1:0] ea, eb, min_val, mag_a, mag_b;
  logic [MULDIV_XLEN-1:0] spec_raw, spec_res, fin_raw, fin_res;

  muldiv_iter u_iter (
    .is_div   (state == DIV),
    .acc      (acc_q),
    .op_a     (opa_q),
    .op_b     (opb_q),
    .acc_nxt  (acc_nxt),
    .op_a_nxt (opa_nxt),
    .op_b_nxt (opb_nxt)
  );

  // Decode the incoming request: effective operands, magnitudes and short-cut results
  always_comb begin
    is_mul    = (alufunc == ALU_MULT);
    is_sdiv   = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
    is_div_op = is_sdiv || (alufunc == ALU_DIVU) || (alufunc == ALU_REMU);
    is_rem    = (alufunc == ALU_REM) || (alufunc == ALU_REMU);
    if (word) begin
      ea      = (is_mul || is_sdiv) ? sext32(a[31:0]) : {32'b0, a[31:0]};
      eb      = (is_mul || is_sdiv) ? sext32(b[31:0]) : {32'b0, b[31:0]};
      min_val = {{33{1'b1}}, 31'b0};
    end else begin
      ea      = a;
      eb      = b;
      min_val = {1'b1, {(MULDIV_XLEN-1){1'b0}}};
    end
    neg_a    = is_sdiv & ea[MULDIV_XLEN-1];
    neg_b    = is_sdiv & eb[MULDIV_XLEN-1];
    mag_a    = neg_a ? -ea : ea;
    mag_b    = neg_b ? -eb : eb;
    div0     = (eb == '0);
    ovf      = is_sdiv && (ea == min_val) && (eb == '1);
    special  = !is_mul && (!is_div_op || div0 || ovf);
    spec_raw = '0;
    if (is_div_op) begin
      if (div0)     spec_raw = is_rem ? ea : '1;
      else if (ovf) spec_raw = is_rem ? '0 : ea;
    end
    spec_res = word ? sext32(spec_raw[31:0]) : spec_raw;
  end

  // Final-iteration result with sign fixup applied to quotient or remainder
  always_comb begin
    rem_q   = (func_q == ALU_REM) || (func_q == ALU_REMU);
    last    = (cnt == (word_q ? 7'(MULDIV_ITER_W - 1) : 7'(MULDIV_ITER_D - 1)));
    fin_raw = acc_nxt;
    if (state == DIV) begin
      if (rem_q) fin_raw = neg_r_q ? -acc_nxt : acc_nxt;
      else       fin_raw = neg_q_q ? -opa_nxt : opa_nxt;
    end
    fin_res = word_q ? sext32(fin_raw[31:0]) : fin_raw;
  end

  // State register; reset wins over flush and handshake
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; flush overrides every transition
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) state_nxt = special ? DONE : (is_mul ? MUL : DIV);
      end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

  // Operand latch on accept, one iteration per cycle, result capture on the last step
  always_ff @(posedge clk) begin
    if (!reset) begin
      func_q   <= ALU_ADD;
      word_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt      <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      func_q  <= alufunc;
      word_q  <= word;
      neg_q_q <= neg_a ^ neg_b;
      neg_r_q <= neg_a;
      cnt     <= '0;
      acc_q   <= '0;
      if (is_mul) begin
        opa_q <= ea;
        opb_q <= eb;
      end else begin
        // W divides run 32 steps, so the magnitude starts in the upper half
        opa_q <= word ? {mag_a[31:0], 32'b0} : mag_a;
        opb_q <= mag_b;
      end
      if (special) result_q <= spec_res;
    end else if (state == MUL || state == DIV) begin
      acc_q <= acc_nxt;
      opa_q <= opa_nxt;
      opb_q <= opb_nxt;
      cnt   <= cnt + 7'd1;
      if (last) result_q <= fin_res;
    end
  end

endmodule
